// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN / PC_STEP   : datapath width and sequential PC increment
//   fetch_entry_t    : one queued fetch result {pc, instruction}
//   fetch_state_t    : fetch state machine encoding
//   pc_aligned()     : word-alignment check for redirect targets
package fetch_pkg;

  localparam int          XLEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_t;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: fetch-to-decode valid/ready handshake.
//   out_valid       : head of fetch queue is valid (master -> slave)
//   out_ready       : decode accepts the head this cycle (slave -> master)
//   out_pc          : PC of the head entry, 0 when not valid
//   out_instruction : instruction word of the head entry, 0 when not valid
interface fetch_if;
  import fetch_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instruction;

  modport master (output out_valid, output out_pc, output out_instruction, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instruction, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t.
//   clk, reset_n  : clock, asynchronous active-low reset
//   push_i        : request to write push_data_i at tail
//   push_data_i   : entry to write
//   pop_i         : request to remove the head entry
//   flush_i       : empty the queue; overrides push and pop
//   push_accept_o : push_i was taken this cycle (room, or full with a pop)
//   head_o        : current head entry
//   full_o/empty_o: occupancy flags
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         push_accept_o,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           pop_ok_s;
  logic           push_ok_s;

  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == {CW{1'b0}});
  assign head_o        = mem_q[head_q];
  assign pop_ok_s      = pop_i && !empty_o && !flush_i;
  // A full queue can still take a new entry when the head leaves on the same edge.
  assign push_ok_s     = push_i && !flush_i && (!full_o || pop_ok_s);
  assign push_accept_o = push_ok_s;

  // Next-state pointer and occupancy logic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_ok_s) begin
        head_d = head_q + PW'(1'b1);
      end else begin
        head_d = head_q;
      end
      if (push_ok_s) begin
        tail_d = tail_q + PW'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers and entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok_s) begin
        mem_q[tail_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
//   clk, reset_n     : clock, asynchronous active-low reset
//   imem_pc          : word-aligned fetch address (straight from the PC register)
//   imem_instruction : word returned combinationally for imem_pc
//   redirect_valid/redirect_pc : branch/jump redirect from execute
//   out_if           : fetch_if master towards decode
//   fetch_fault      : sticky, set by a misaligned redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_if.master         out_if,
  output logic            fetch_fault
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         fault_q;

  logic         run_s;
  logic         redirect_s;
  logic         out_valid_s;
  logic         pop_req_s;
  logic         push_req_s;
  logic         push_accept_s;
  logic         q_full_s;
  logic         q_empty_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;

  assign run_s       = (state_q == FETCH_RUN);
  // Any redirect seen in RUN flushes the queue, aligned or not.
  assign redirect_s  = run_s && redirect_valid;
  assign out_valid_s = run_s && !q_empty_s;
  assign pop_req_s   = out_valid_s && out_if.out_ready && !redirect_s;
  assign push_req_s  = run_s && !redirect_s;
  assign push_data_s = '{pc: pc_q, instruction: imem_instruction};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_i        (push_req_s),
    .push_data_i   (push_data_s),
    .pop_i         (pop_req_s),
    .flush_i       (redirect_s),
    .push_accept_o (push_accept_s),
    .head_o        (head_s),
    .full_o        (q_full_s),
    .empty_o       (q_empty_s)
  );

  assign imem_pc                = pc_q;
  assign fetch_fault            = fault_q;
  assign out_if.out_valid       = out_valid_s;
  assign out_if.out_pc          = out_valid_s ? head_s.pc : 32'h0000_0000;
  assign out_if.out_instruction = out_valid_s ? head_s.instruction : 32'h0000_0000;

  // Fetch state machine: PC advance, redirect handling and sticky fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (redirect_valid) begin
            if (pc_aligned(redirect_pc)) begin
              pc_q <= redirect_pc;
            end else begin
              // PC is left where it was; only reset leaves FAULT.
              state_q <= FETCH_FAULT;
              fault_q <= 1'b1;
            end
          end else if (push_accept_s) begin
            pc_q <= pc_q + PC_STEP;
          end else begin
            pc_q <= pc_q;
          end
        end
        FETCH_FAULT: begin
          state_q <= FETCH_FAULT;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= FETCH_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // q_full_s is only consumed inside the queue's own push decision.
  logic unused_s;
  assign unused_s = q_full_s;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected {pc, instruction}
// pops; a negedge monitor compares every accepted head against the queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_entry_t sb_q[$];

  fetch_if u_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_if           (u_if),
    .fetch_fault      (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory model: fixed word at 0, address-derived words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h00A0_0093;
    else return a ^ 32'h5A5A_0013;
  endfunction

  always_comb imem_instruction = mem_word(imem_pc);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic void expect_pc(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc = pc;
    e.instruction = mem_word(pc);
    sb_q.push_back(e);
  endfunction

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1
        && redirect_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop_pc", u_if.out_pc, 32'hFFFF_FFFF);
      end else begin
        fetch_entry_t e;
        e = sb_q.pop_front();
        check("pop_pc", u_if.out_pc, e.pc);
        check("pop_instr", u_if.out_instruction, e.instruction);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    u_if.out_ready = ready;
    tick();
    tick();
    check("sb_empty_before_test", 32'(sb_q.size()), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    u_if.out_ready = 1'b0;
    tick();
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_out_pc", u_if.out_pc, 32'd0);
    check("rst_out_instr", u_if.out_instruction, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_imem_pc", imem_pc, 32'h0000_0000);

    // Streaming with out_ready=1.
    do_reset(1'b1);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    check("t1_first_cycle_invalid", 32'(u_if.out_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    u_if.out_ready = 1'b0;
    check("t1_sb_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure: queue fills, PC stalls, then drains without gaps.
    do_reset(1'b0);
    check("t2_imem_pc_start", imem_pc, 32'h0);
    tick();
    check("t2_valid_after_first_edge", 32'(u_if.out_valid), 32'd1);
    tick();
    check("t2_head_pc_c2", u_if.out_pc, 32'h0);
    tick(); tick(); tick();
    check("t2_imem_pc_stall", imem_pc, 32'h8);
    check("t2_head_pc_stable", u_if.out_pc, 32'h0);
    check("t2_head_instr_stable", u_if.out_instruction, 32'h00A0_0093);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_no_gap_valid", 32'(u_if.out_valid), 32'd1);
      tick();
    end
    u_if.out_ready = 1'b0;
    check("t2_sb_drained", 32'(sb_q.size()), 32'd0);

    // Redirect while queue holds pc 0 and 4.
    do_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    expect_pc(32'h10); expect_pc(32'h14);
    tick();
    redirect_valid = 1'b0;
    check("t3_valid_after_redirect", 32'(u_if.out_valid), 32'd0);
    check("t3_imem_pc_redirect", imem_pc, 32'h10);
    tick();
    check("t3_valid_n2", 32'(u_if.out_valid), 32'd1);
    check("t3_out_pc_n2", u_if.out_pc, 32'h10);
    u_if.out_ready = 1'b1;
    tick(); tick();
    u_if.out_ready = 1'b0;
    check("t3_sb_drained", 32'(sb_q.size()), 32'd0);

    // Redirect coinciding with a pop: the popped entry is dropped.
    do_reset(1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    expect_pc(32'h8); expect_pc(32'hC);
    tick();
    redirect_valid = 1'b0;
    check("t4_valid_after_redirect", 32'(u_if.out_valid), 32'd0);
    check("t4_imem_pc_redirect", imem_pc, 32'h8);
    tick(); tick(); tick();
    u_if.out_ready = 1'b0;
    check("t4_sb_drained", 32'(sb_q.size()), 32'd0);

    // Misaligned redirect: sticky fault, later redirects ignored, reset clears.
    do_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0006;
    tick();
    redirect_valid = 1'b0;
    check("t5_fault_set", 32'(fetch_fault), 32'd1);
    check("t5_valid_flushed", 32'(u_if.out_valid), 32'd0);
    check("t5_pc_unchanged", imem_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    tick();
    redirect_valid = 1'b0;
    tick();
    u_if.out_ready = 1'b1;
    tick();
    check("t5_redirect_ignored_pc", imem_pc, 32'h8);
    check("t5_fault_sticky", 32'(fetch_fault), 32'd1);
    check("t5_valid_stays_low", 32'(u_if.out_valid), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_fault_clear", 32'(fetch_fault), 32'd0);
    check("t5_async_imem_pc", imem_pc, 32'h0);
    check("t5_async_out_pc", u_if.out_pc, 32'h0);

    // Wrap-around of PC across 2^32.
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000); expect_pc(32'h0000_0004);
    tick();
    redirect_valid = 1'b0;
    check("t6_imem_pc_redirect", imem_pc, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) tick();
    u_if.out_ready = 1'b0;
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of `instruction_memory`. It owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures each returned word with its PC in a small queue. It presents fetched instructions to decode over a valid/ready handshake, and accepts branch/jump redirects from execute, which flush all in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- `QUEUE_DEPTH`, 2, fetch queue entries; power of two, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_pc` out 32: fetch address to `instruction_memory.pc`.
- `imem_instruction` in 32: word returned combinationally for `imem_pc`.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in 32: new PC, sampled when `redirect_valid`=1.
- `out_valid` out 1: queue head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 32: PC of head entry.
- `out_instruction` out 32: instruction word of head entry.
- `fetch_fault` out 1: sticky; a misaligned redirect was received.

## Operation
- State machine has two states:
  - RUN: normal fetch.
  - FAULT: fetch halted. Left only by reset.
- Registers:
  - `pc`: 32 bits. Drives `imem_pc` directly (no combinational path from inputs).
  - Queue: entries of {pc, instruction}, plus head/tail pointers and a count.
- Pop: `out_valid && out_ready`. The head is removed at the clock edge.
- Push (RUN, no redirect): occurs when count < QUEUE_DEPTH, or the queue is full and a pop happens the same cycle. The entry {pc, imem_instruction} is written at tail and `pc <= pc + 4`. Otherwise `pc` holds.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no fault on wrap.
- Redirect (`redirect_valid`=1, RUN, `redirect_pc[1:0]`=0):
  - The queue is flushed (count=0, pointers reset) and `pc <= redirect_pc`.
  - No push occurs that cycle, and any concurrent pop is discarded.
  - Redirect has priority over push and pop.
- Misaligned redirect (`redirect_pc[1:0]`≠0):
  - Queue flushed, `pc` unchanged, state goes to FAULT, `fetch_fault` goes to 1.
- FAULT: no pushes; `out_valid`=0; redirects are ignored.
- When `out_valid`=0, `out_pc` and `out_instruction` are driven to 0.
- `redirect_valid` in FAULT has no effect; a second misaligned redirect in FAULT likewise has no effect.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk`):
  - `pc`=RESET_PC, so `imem_pc`=RESET_PC.
  - `out_valid`=0, `out_pc`=0, `out_instruction`=0, `fetch_fault`=0, queue empty, state RUN.
- Fetch latency: an instruction is pushed on the first edge after reset release and is visible (`out_valid`=1) one cycle later. The queue is registered, so there is no same-cycle bypass.
- Steady state with `out_ready`=1 continuously: one instruction per cycle, with `out_pc` increasing by 4 each cycle.
- With `out_ready`=0: the queue fills after QUEUE_DEPTH pushes, then `pc` stalls at the next unfetched address.
- Redirect at edge N: `out_valid`=0 in cycle N+1, and `imem_pc`=redirect_pc in cycle N+1. The first redirected instruction has `out_valid`=1 in cycle N+2. Redirect penalty is 2 cycles.
- Handshake rule: while `out_valid`=1 and `out_ready`=0, `out_pc` and `out_instruction` hold stable until a pop or a redirect.
- Reset mid-operation: all in-flight entries are lost immediately, and outputs return to reset values within the same cycle.

## Structure
- Package `fetch_pkg` holds:
  - `XLEN`=32 and `PC_STEP`=4.
  - typedef `fetch_entry_t` {logic [31:0] pc; logic [31:0] instruction}.
  - enum `fetch_state_t` {FETCH_RUN, FETCH_FAULT}.
- One sub-module, `fetch_queue`: a synchronous FIFO of `fetch_entry_t` with push, pop, flush, full, empty and head outputs. It contains the pointer/count logic and the full-with-pop push case.
- `fetch_unit` contains the PC register, the state machine, and redirect/alignment checks.

## Test plan
- **Reset, then `out_ready`=1:** `out_pc` sequence 0,4,8,12 on consecutive cycles starting 2 cycles after release. `out_instruction` matches the memory word at each address; the word at 0 is 32'h00A00093.
- **`out_ready`=0 for 5 cycles after reset:** count saturates at 2 and `imem_pc` holds at 8. Head stays pc=0 with a stable instruction. On raising `out_ready`, pops yield 0,4,8 with no gap.
- **Redirect to 32'h10 while the queue holds pc 0 and 4:** next cycle `out_valid`=0 and `imem_pc`=0x10. Two cycles later `out_pc`=0x10. pc 0 and 4 never pop.
- **Redirect and pop in the same cycle:** the popped entry is dropped and there is no duplicate output. Redirect target 0x8 is produced next.
- **Redirect to 32'h6:** `fetch_fault`=1 next cycle and `out_valid` stays 0. A later redirect to 0x0 is ignored. Asserting `reset_n`=0 clears the fault immediately.
- **Redirect to 32'hFFFF_FFF8 with `out_ready`=1:** `out_pc` runs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
